ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
- Hardware return-address stack for the WISC-15 core; the producer side of the next-PC return path.
- A call pushes the link address (In_pc+1), and a ret pops it. The top-of-stack value feeds the next-PC logic's Ret_reg input in the same cycle as the ret.
- Sits beside the PC register and is sampled with the same clk edge that updates the PC.

Parameters:
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- AW, 16, address width in bits; matches PC width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- call  input  1  decoded call instruction this cycle.
- ret  input  1  decoded ret instruction this cycle.
- halt  input  1  core halted; blocks all push/pop.
- link_addr  input  AW  address pushed on call (In_pc+1).
- ret_addr  output  AW  current top-of-stack entry, combinational; drives Ret_reg.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- ovf  output  1  sticky: a push occurred while full (only with RAS_ERR_FLAGS_EN).
- unf  output  1  sticky: a pop occurred while empty (only with RAS_ERR_FLAGS_EN).
- err_clr  input  1  synchronous clear of ovf/unf (only with RAS_ERR_FLAGS_EN).

Behaviour:
- Reset (async assert, sync release): sp=0, count=0, empty=1, full=0, ovf=0, unf=0. Entry contents are unreset; ret_addr reads 0 while empty.
- Storage: DEPTH x AW register array. The sp register points to the next free slot. The top entry is mem[sp-1] modulo DEPTH.
- ret_addr is combinational from mem[sp-1] when count>0, else 0. There is zero latency from the stack to Ret_reg.
- Operation priority mirrors next-PC priority: halt > call > ret.
  - halt=1: no state change regardless of call/ret.
  - call=1 (ret ignored): at the clock edge, write link_addr to mem[sp], sp=sp+1 mod DEPTH, count=min(count+1,DEPTH).
  - ret=1, call=0: at the clock edge, sp=sp-1 mod DEPTH and count=count-1, if count>0.
- Push when full: circular overwrite of the oldest entry. sp still advances and count stays DEPTH; ovf sets.
- Pop when empty: no change to sp or count; ret_addr stays 0; unf sets.
- Calls nested deeper than DEPTH return correctly for the innermost DEPTH levels. Deeper returns underflow.
- A push followed by a pop in the next cycle returns the just-pushed link_addr. There is no bypass inside a single cycle: ret_addr reflects pre-edge state.
- Pointer arithmetic is unsigned, width $clog2(DEPTH), and wraps naturally.
- err_clr clears ovf/unf at the edge. A new error in the same cycle wins, so the flag stays set.
- Reset asserted mid-operation discards pending push/pop immediately. The stack is empty after release.

Optional Feature:
- Macro: RAS_ERR_FLAGS_EN.
- Defined: the ovf/unf sticky flags and the err_clr input exist as described.
- Undefined: the ovf, unf and err_clr ports are absent and no flag registers are built. Overwrite-on-full and ignore-on-empty behaviour is unchanged.

Decomposition:
- Shared package wisc_pkg holds:
  - the PC width constant (16);
  - the default RAS depth constant (8);
  - a localparam for the pointer width derived via $clog2.
- One natural sub-module: ras_ptr, an up/down wrap-around pointer plus saturating count.
  - Inputs: inc, dec.
  - Outputs: sp, count, empty, full.
- The storage array and the ret_addr mux stay in the top module.

Test Plan:
- Reset, then idle: ret_addr=0x0000, empty=1, count=0, ovf=unf=0.
- Push 0x0011, 0x0022, 0x0033 on successive cycles, then three rets:
  - ret_addr reads 0x0033, 0x0022, 0x0011 in the ret cycles;
  - empty=1 at the end.
- DEPTH=8, push 0x0100..0x0108 (9 calls):
  - full=1, ovf=1, count=8;
  - 8 pops yield 0x0108 down to 0x0101;
  - a 9th pop sets unf=1 with ret_addr=0x0000.
- call=1 and ret=1 in the same cycle with link_addr=0x0ABC: push only, count +1, ret_addr=0x0ABC next cycle.
- halt=1 with call=1 and link_addr=0x0F00: count, sp and ret_addr are unchanged. After halt=0, the ret path still returns the prior top.
- Assert rst asynchronously mid-cycle with count=5: empty=1 and ret_addr=0x0000 immediately, before the next clk edge. err_clr clears sticky flags set earlier.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC-15 constants: PC width and default return-address-stack sizing.
package wisc_pkg;
  localparam int PC_W      = 16;
  localparam int RAS_DEPTH = 8;
  localparam int RAS_PW    = $clog2(RAS_DEPTH);
endpackage : wisc_pkg

// File: rtl/ras_ptr.sv
// Return-address-stack pointer: wrap-around stack pointer plus a count that saturates at DEPTH.
module ras_ptr
  import wisc_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] sp,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [PW-1:0] sp_d, sp_q;
  logic [CW-1:0] count_d, count_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign sp    = sp_q;
  assign count = count_q;

  // inc wins over dec; a push on full still advances sp so the oldest entry is overwritten
  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    if (inc) begin
      sp_d = sp_q + PW'(1);
      if (!full) count_d = count_q + CW'(1);
    end else if (dec && !empty) begin
      sp_d    = sp_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

endmodule : ras_ptr

// File: rtl/ret_addr_stack.sv
// WISC-15 hardware return-address stack feeding Ret_reg combinationally.
// Optional RAS_ERR_FLAGS_EN adds sticky ovf/unf flags and the err_clr input.
module ret_addr_stack
  import wisc_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int AW    = PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     halt,
  input  logic [AW-1:0]            link_addr,
  output logic [AW-1:0]            ret_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
`ifdef RAS_ERR_FLAGS_EN
  ,
  output logic                     ovf,
  output logic                     unf,
  input  logic                     err_clr
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic          push, pop;
  logic [PW-1:0] sp;
  logic [PW-1:0] top_idx;
  logic [AW-1:0] mem_q [DEPTH];

  // halt > call > ret, matching next-PC priority
  assign push = call & ~halt;
  assign pop  = ret & ~call & ~halt;

  ras_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (push),
    .dec   (pop),
    .sp    (sp),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (push) mem_q[sp] <= link_addr;
  end

  assign top_idx  = sp - PW'(1);
  assign ret_addr = empty ? '0 : mem_q[top_idx];

`ifdef RAS_ERR_FLAGS_EN
  logic ovf_d, ovf_q, unf_d, unf_q;

  // a fresh error in the clearing cycle keeps the flag set
  always_comb begin
    ovf_d = (ovf_q & ~err_clr) | (push & full);
    unf_d = (unf_q & ~err_clr) | (pop & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`endif

endmodule : ret_addr_stack

// File: tb/tb_ret_addr_stack.sv
// Self-checking bench for ret_addr_stack: vector table plus hand-written corner sequences.
module tb_ret_addr_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          call = 1'b0, ret = 1'b0, halt = 1'b0;
  logic [AW-1:0] link_addr = '0;
  logic [AW-1:0] ret_addr;
  logic [CW-1:0] count;
  logic          empty, full;
`ifdef RAS_ERR_FLAGS_EN
  logic          ovf, unf;
  logic          err_clr = 1'b0;
`endif

  ret_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .call      (call),
    .ret       (ret),
    .halt      (halt),
    .link_addr (link_addr),
    .ret_addr  (ret_addr),
    .count     (count),
    .empty     (empty),
    .full      (full)
`ifdef RAS_ERR_FLAGS_EN
    ,
    .ovf       (ovf),
    .unf       (unf),
    .err_clr   (err_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          c, r, h;
    logic [AW-1:0] link;
    logic [AW-1:0] exp_ra;     // ret_addr before the edge
    int            exp_cnt;    // count after the edge
  } vec_t;

  typedef struct {
    int   cnt;
    logic emp;
    logic ful;
  } post_t;

  int    n_checks = 0;
  int    n_err    = 0;
  post_t sb_q[$];
  vec_t  tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle: check comb ret_addr before the edge, queue post-edge state, check after edge.
  task automatic step(input vec_t v, input string tag);
    post_t p;
    @(negedge clk);
    call = v.c; ret = v.r; halt = v.h; link_addr = v.link;
    p.cnt = v.exp_cnt;
    p.emp = (v.exp_cnt == 0);
    p.ful = (v.exp_cnt == DEPTH);
    sb_q.push_back(p);
    #1;
    chk({tag, " ret_addr"}, 32'(ret_addr), 32'(v.exp_ra));
    @(posedge clk);
    #1;
    p = sb_q.pop_front();
    chk({tag, " count"}, 32'(count), 32'(p.cnt));
    chk({tag, " empty"}, 32'(empty), 32'(p.emp));
    chk({tag, " full"},  32'(full),  32'(p.ful));
    call = 1'b0; ret = 1'b0; halt = 1'b0;
  endtask

  function automatic vec_t mk(input logic c, r, h, input logic [AW-1:0] l, ra, input int cnt);
    vec_t v;
    v.c = c; v.r = r; v.h = h; v.link = l; v.exp_ra = ra; v.exp_cnt = cnt;
    return v;
  endfunction

  initial begin
    // basic LIFO, call+ret, halt, underflow
    tbl.push_back(mk(1, 0, 0, 16'h0011, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 0, 16'h0022, 16'h0011, 2));
    tbl.push_back(mk(1, 0, 0, 16'h0033, 16'h0022, 3));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0033, 2));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0022, 1));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0011, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0ABC, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0ABC, 1));
    tbl.push_back(mk(1, 0, 1, 16'h0F00, 16'h0ABC, 1));
    tbl.push_back(mk(0, 1, 1, 16'h0000, 16'h0ABC, 1));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0ABC, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset ret_addr", 32'(ret_addr), 32'h0);
    chk("reset count",    32'(count),    32'd0);
    chk("reset empty",    32'(empty),    32'd1);
    chk("reset full",     32'(full),     32'd0);
`ifdef RAS_ERR_FLAGS_EN
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset unf", 32'(unf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

`ifdef RAS_ERR_FLAGS_EN
    chk("unf after pop-empty", 32'(unf), 32'd1);
    chk("ovf still clear",     32'(ovf), 32'd0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("unf cleared", 32'(unf), 32'd0);
`endif

    // overflow: 9 calls into an 8-deep stack
    for (int i = 0; i < 9; i++)
      step(mk(1, 0, 0, 16'(16'h0100 + i), (i == 0) ? 16'h0000 : 16'(16'h0100 + i - 1),
              (i + 1 > DEPTH) ? DEPTH : i + 1), $sformatf("ovf_call%0d", i));
`ifdef RAS_ERR_FLAGS_EN
    chk("ovf set", 32'(ovf), 32'd1);
`endif
    for (int j = 0; j < 8; j++)
      step(mk(0, 1, 0, 16'h0, 16'(16'h0108 - j), 7 - j), $sformatf("ovf_pop%0d", j));
`ifdef RAS_ERR_FLAGS_EN
    chk("unf clear before 9th pop", 32'(unf), 32'd0);
    // 9th pop underflows while err_clr is asserted: the new error wins
    @(negedge clk);
    err_clr = 1'b1;
`endif
    step(mk(0, 1, 0, 16'h0, 16'h0000, 0), "pop9");
`ifdef RAS_ERR_FLAGS_EN
    err_clr = 1'b0;
    chk("unf set on 9th pop", 32'(unf), 32'd1);
    chk("ovf cleared by err_clr", 32'(ovf), 32'd0);
`endif
    chk("ret_addr after underflow", 32'(ret_addr), 32'h0);

    // async reset mid-cycle with 5 entries
    for (int i = 0; i < 5; i++)
      step(mk(1, 0, 0, 16'(16'h0200 + i), (i == 0) ? 16'h0000 : 16'(16'h0200 + i - 1), i + 1),
           $sformatf("pre_rst%0d", i));
    chk("pre-reset top", 32'(ret_addr), 32'h0204);
    @(posedge clk);
    #2;
    call = 1'b1; link_addr = 16'h0BAD;
    rst = 1'b1;
    #1;
    chk("async rst count",    32'(count),    32'd0);
    chk("async rst empty",    32'(empty),    32'd1);
    chk("async rst ret_addr", 32'(ret_addr), 32'h0);
`ifdef RAS_ERR_FLAGS_EN
    chk("async rst unf", 32'(unf), 32'd0);
`endif
    @(negedge clk);
    call = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst empty", 32'(empty), 32'd1);
    step(mk(1, 0, 0, 16'h0777, 16'h0000, 1), "post_rst_call");
    step(mk(0, 1, 0, 16'h0000, 16'h0777, 0), "post_rst_ret");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_ret_addr_stack
